// File: rtl/key_rx_pkg.sv
// Shared types and constants for the key_rx UART keyboard receiver.
// Holds the FSM state enum, the no-key / enter codes, the allowed-key set
// used when KEY_FILTER_EN is defined, and small byte helpers.
package key_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        EMIT      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    localparam logic [7:0] NO_KEY    = 8'h2A;
    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_9     = 8'h39;
    localparam logic [7:0] KEY_B     = 8'h62;
    localparam logic [7:0] KEY_C     = 8'h63;
    localparam logic [7:0] KEY_W     = 8'h77;
    localparam logic [7:0] KEY_T     = 8'h74;
    localparam logic [7:0] KEY_Q     = 8'h71;

    // Upper-case ASCII letters fold to lower case; everything else passes.
    function automatic logic [7:0] fold_key(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) begin
            return b + 8'h20;
        end
        return b;
    endfunction

    // Membership in the filtered key set (digits, b c w t q, enter).
    function automatic logic key_allowed(input logic [7:0] k);
        return (k >= KEY_0 && k <= KEY_9) || k == KEY_B || k == KEY_C ||
               k == KEY_W || k == KEY_T || k == KEY_Q || k == KEY_ENTER;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (idle line).
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_rx.sv
// UART 8N1 keyboard receiver: deserializes bytes from rx, folds upper case
// to lower case, drops the no-key code, and presents each key for one cycle.
// Optional macro KEY_FILTER_EN restricts emitted keys to the allowed set.
// Ports: clk, rst (async active-high), rx (async serial line, idle high),
//        ascii_code (key or 8'h2A), key_valid (1-cycle key strobe),
//        frame_err (1-cycle pulse on a bad stop bit).
module key_rx
    import key_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ascii_code,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
    localparam int unsigned LAST         = (CLKS_PER_BIT > 0) ? CLKS_PER_BIT - 1 : 0;

    logic             rx_s;
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       sr, sr_d;
    logic [7:0]       ascii_d;
    logic             valid_d, ferr_d;
    logic [7:0]       folded_c;
    logic             emit_ok_c;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign folded_c = fold_key(sr);

    // The drop test uses the raw byte; the filter applies after folding.
`ifdef KEY_FILTER_EN
    assign emit_ok_c = (sr != NO_KEY) && key_allowed(folded_c);
`else
    assign emit_ok_c = (sr != NO_KEY);
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            ascii_code <= NO_KEY;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            sr         <= sr_d;
            ascii_code <= ascii_d;
            key_valid  <= valid_d;
            frame_err  <= ferr_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sr_d    = sr;
        ascii_d = NO_KEY;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject glitches.
                if (cnt == CNT_W'(HALF_M1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(LAST)) begin
                    cnt_d    = '0;
                    sr_d[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_W'(LAST)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = EMIT;
                    end else begin
                        ferr_d  = 1'b1;
                        sr_d    = '0;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            EMIT: begin
                state_d = IDLE;
                if (emit_ok_c) begin
                    ascii_d = folded_c;
                    valid_d = 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A stuck-low line must not look like a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_rx.sv
module tb_key_rx;
    import key_rx_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] ascii_code;
    logic       key_valid;
    logic       frame_err;

    typedef struct {
        bit         ferr;
        logic [7:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    key_rx #(.CLK_FREQ(1600), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .ascii_code (ascii_code),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference behaviour of one good frame, straight from the key rules.
    task automatic push_frame(input logic [7:0] b, input bit stop_bit);
        exp_t e;
        logic [7:0] k;
        bit emit;
        if (!stop_bit) begin
            e.ferr = 1'b1;
            e.key  = NO_KEY;
            exp_q.push_back(e);
            return;
        end
        k    = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
        emit = (b != 8'h2A);
`ifdef KEY_FILTER_EN
        emit = emit && ((k >= 8'h30 && k <= 8'h39) ||
                        (k inside {8'h62, 8'h63, 8'h77, 8'h74, 8'h71, 8'h0D}));
`endif
        if (emit) begin
            e.ferr = 1'b0;
            e.key  = k;
            exp_q.push_back(e);
        end
    endtask

    // Drive start + nbits data bits (+ stop when the frame is complete).
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int nbits);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        if (nbits == 8) begin
            rx = stop_bit;
            repeat (CPB) @(posedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_bit);
        push_frame(b, stop_bit);
        send_frame(b, stop_bit, 8);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic expect_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every output cycle is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid && frame_err) begin
                check("valid_and_ferr", 32'd1, 32'd0);
            end else if (key_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {15'd0, frame_err, 8'd0, ascii_code}, {16'd0, 8'd0, NO_KEY});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ferr_flag", 32'(frame_err), 32'(e.ferr));
                    if (!e.ferr) check("key", 32'(ascii_code), 32'(e.key));
                end
            end else if (ascii_code !== NO_KEY) begin
                check("idle_code", 32'(ascii_code), 32'(NO_KEY));
            end
        end
    end

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        #1;
        check("reset_ascii", 32'(ascii_code), 32'(NO_KEY));
        check("reset_valid", 32'(key_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * CPB);

        // Single digit, then a folded letter.
        send(8'h35, 1'b1); expect_drained("digit_5_latency");
        idle(CPB);
        send(8'h51, 1'b1); expect_drained("Q_folds");
        idle(CPB);

        // Bad stop bit, line held low, then recovery.
        send(8'h35, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        expect_drained("frame_err_pulse");
        idle(CPB);
        send(8'h0D, 1'b1); expect_drained("enter_after_ferr");
        idle(CPB);

        // Short glitch is rejected; the no-key code is dropped.
        rx = 1'b0;
        repeat (5) @(posedge clk);
        idle(2 * CPB);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        send(8'h2A, 1'b1);
        idle(CPB);
        expect_drained("no_key_dropped");

        // Back-to-back keys.
        send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h33, 1'b1);
        send(8'h34, 1'b1); send(8'h0D, 1'b1);
        idle(CPB);
        expect_drained("back_to_back");

        // Reset in the middle of the third frame.
        send(8'h31, 1'b1); send(8'h32, 1'b1);
        send_frame(8'h33, 1'b1, 4);
        #1 rst = 1'b1;
        #1;
        check("midrst_ascii", 32'(ascii_code), 32'(NO_KEY));
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * CPB);
        send(8'h34, 1'b1); send(8'h0D, 1'b1);
        idle(CPB);
        expect_drained("after_midrst");

        // Filter behaviour: 'x' then 'w'.
        send(8'h78, 1'b1); send(8'h77, 1'b1);
        idle(CPB);
        expect_drained("x_then_w");

        // Randomized traffic, mostly good frames.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit sb;
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 7) != 0);
            send(b, sb);
            if (!sb || $urandom_range(0, 3) == 0) idle(CPB);
        end

        // Bounded drain of anything still in flight.
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        expect_drained("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
